// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC decimator sequencer:
// FSM state encodings, comb-select width and the decimation-rate clamp.
package cic_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      COMB = 2'd2
   } cic_state_e;

   function automatic int sel_w(input int stages);
      return (stages > 1) ? $clog2(stages) : 1;
   endfunction

   // A zero rate could never wrap, so it is treated as decimate-by-one.
   function automatic logic [31:0] clamp_rate(input logic [31:0] rate);
      return (rate == 32'd0) ? 32'd1 : rate;
   endfunction

endpackage

// File: rtl/cic_phase_counter.sv
// Sample phase counter with pending/active decimation-rate registers.
// wrap marks the input sample that closes a decimation block.
module cic_phase_counter
   import cic_pkg::*;
#(
   parameter int RATE_W       = 16,
   parameter int DEFAULT_RATE = 80
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              clear,
   input  logic              in_strobe,
   input  logic              rate_load,
   input  logic [RATE_W-1:0] rate,
   output logic [RATE_W-1:0] active_rate,
   output logic              wrap
);

   localparam logic [RATE_W-1:0] ONE        = RATE_W'(1);
   localparam logic [RATE_W-1:0] RESET_RATE = RATE_W'(DEFAULT_RATE);

   logic [RATE_W-1:0] phase_q, phase_d;
   logic [RATE_W-1:0] active_q, active_d;
   logic [RATE_W-1:0] pending_q, pending_d;
   logic              at_end_s;

   // A load coinciding with a wrap goes straight into the next block's rate.
   always_comb begin
      pending_d = rate_load ? RATE_W'(clamp_rate(32'(rate))) : pending_q;
      at_end_s  = (phase_q == (active_q - ONE));
      wrap      = run & ~clear & in_strobe & at_end_s;
      phase_d   = phase_q;
      active_d  = active_q;
      if (!run) begin
         phase_d  = '0;
         active_d = pending_d;
      end else if (clear) begin
         phase_d  = '0;
         active_d = active_q;
      end else if (wrap) begin
         phase_d  = '0;
         active_d = pending_d;
      end else if (in_strobe) begin
         phase_d  = phase_q + ONE;
         active_d = active_q;
      end else begin
         phase_d  = phase_q;
         active_d = active_q;
      end
   end

   // Phase and rate registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase_q   <= '0;
         active_q  <= RESET_RATE;
         pending_q <= RESET_RATE;
      end else begin
         phase_q   <= phase_d;
         active_q  <= active_d;
         pending_q <= pending_d;
      end
   end

   assign active_rate = active_q;

endmodule

// File: rtl/cic_decim_sequencer.sv
// Sequencer for one CIC decimator channel: gates the integrator strobe and
// walks a shared comb subtractor across all stages after each decimation point.
module cic_decim_sequencer
   import cic_pkg::*;
#(
   parameter  int STAGES       = 5,
   parameter  int RATE_W       = 16,
   parameter  int DEFAULT_RATE = 80,
   localparam int SEL_W        = sel_w(STAGES)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [RATE_W-1:0] rate,
   input  logic              rate_load,
   input  logic              in_strobe,
   output logic              int_strobe,
   output logic              comb_en,
   output logic [SEL_W-1:0]  comb_sel,
   output logic              out_strobe,
   output logic              busy,
   output logic              overrun,
   output logic [RATE_W-1:0] active_rate
);

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(STAGES - 1);
   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

   cic_state_e       state_q, state_d;
   logic [SEL_W-1:0] comb_sel_q, comb_sel_d;
   logic             comb_en_q, comb_en_d;
   logic             out_strobe_q, out_strobe_d;
   logic             overrun_q, overrun_d;
   logic             running_s, stop_s, wrap_s;

   assign running_s  = (state_q != IDLE);
   assign stop_s     = ~enable;
   assign int_strobe = in_strobe & running_s;

   cic_phase_counter #(
      .RATE_W       (RATE_W),
      .DEFAULT_RATE (DEFAULT_RATE)
   ) u_phase (
      .clock       (clock),
      .reset       (reset),
      .run         (running_s),
      .clear       (stop_s),
      .in_strobe   (in_strobe),
      .rate_load   (rate_load),
      .rate        (rate),
      .active_rate (active_rate),
      .wrap        (wrap_s)
   );

   // Next-state logic; a wrap seen while combing is dropped and flagged.
   always_comb begin
      state_d      = state_q;
      comb_sel_d   = comb_sel_q;
      comb_en_d    = 1'b0;
      out_strobe_d = 1'b0;
      if (rate_load) begin
         overrun_d = 1'b0;
      end else if (wrap_s && (state_q == COMB)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end
      if (!enable) begin
         state_d    = IDLE;
         comb_sel_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = RUN;
            end
            RUN: begin
               if (wrap_s) begin
                  state_d    = COMB;
                  comb_sel_d = '0;
                  comb_en_d  = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
            COMB: begin
               if (comb_sel_q == LAST_SEL) begin
                  state_d      = RUN;
                  comb_sel_d   = '0;
                  out_strobe_d = 1'b1;
               end else begin
                  comb_sel_d = comb_sel_q + SEL_ONE;
                  comb_en_d  = 1'b1;
               end
            end
            default: begin
               state_d    = IDLE;
               comb_sel_d = '0;
            end
         endcase
      end
   end

   // FSM and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         comb_sel_q   <= '0;
         comb_en_q    <= 1'b0;
         out_strobe_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         comb_sel_q   <= comb_sel_d;
         comb_en_q    <= comb_en_d;
         out_strobe_q <= out_strobe_d;
         overrun_q    <= overrun_d;
      end
   end

   assign comb_en    = comb_en_q;
   assign busy       = comb_en_q;
   assign comb_sel   = comb_sel_q;
   assign out_strobe = out_strobe_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_cic_decim_sequencer.sv
// Directed bench for cic_decim_sequencer: expected comb schedules and out_strobe
// cycles are queued when a strobe is driven and compared by a negedge monitor.
module tb_cic_decim_sequencer;

   localparam int STAGES = 5;
   localparam int RATE_W = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              enable;
   logic [RATE_W-1:0] rate;
   logic              rate_load;
   logic              in_strobe;
   logic              int_strobe;
   logic              comb_en;
   logic [2:0]        comb_sel;
   logic              out_strobe;
   logic              busy;
   logic              overrun;
   logic [RATE_W-1:0] active_rate;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit model_run = 1'b0;
   int st_q[$];
   int en_q[$];
   int out_q[$];
   bit mon_en;
   bit mon_out;
   int mon_sel;

   cic_decim_sequencer #(
      .STAGES       (STAGES),
      .RATE_W       (RATE_W),
      .DEFAULT_RATE (80)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .rate        (rate),
      .rate_load   (rate_load),
      .in_strobe   (in_strobe),
      .int_strobe  (int_strobe),
      .comb_en     (comb_en),
      .comb_sel    (comb_sel),
      .out_strobe  (out_strobe),
      .busy        (busy),
      .overrun     (overrun),
      .active_rate (active_rate)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One input sample; ev marks it as a decimation point that must be combed.
   task automatic pulse(input bit ev, input int gap);
      in_strobe = 1'b1;
      #1;
      check("int_strobe", 32'(int_strobe), 32'(model_run));
      if (ev) begin
         st_q.push_back(cyc + 1);
         en_q.push_back(cyc + STAGES);
         out_q.push_back(cyc + STAGES + 1);
      end
      step();
      in_strobe = 1'b0;
      rate_load = 1'b0;
      repeat (gap - 1) step();
   endtask

   task automatic load_rate(input logic [RATE_W-1:0] r);
      rate      = r;
      rate_load = 1'b1;
      step();
      rate_load = 1'b0;
   endtask

   task automatic enable_on();
      enable = 1'b1;
      step();
      model_run = 1'b1;
   endtask

   task automatic enable_off();
      enable = 1'b0;
      step();
      model_run = 1'b0;
   endtask

   always @(negedge clock) begin
      mon_en  = 1'b0;
      mon_out = 1'b0;
      mon_sel = 0;
      if (st_q.size() > 0 && cyc >= st_q[0]) begin
         mon_en  = 1'b1;
         mon_sel = cyc - st_q[0];
      end
      if (out_q.size() > 0 && cyc == out_q[0]) mon_out = 1'b1;
      check("comb_en", 32'(comb_en), 32'(mon_en));
      check("busy", 32'(busy), 32'(mon_en));
      if (mon_en) check("comb_sel", 32'(comb_sel), mon_sel);
      check("out_strobe", 32'(out_strobe), 32'(mon_out));
      if (mon_en && cyc == en_q[0]) begin
         void'(st_q.pop_front());
         void'(en_q.pop_front());
      end
      if (mon_out) void'(out_q.pop_front());
   end

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      rate      = '0;
      rate_load = 1'b0;
      in_strobe = 1'b0;
      step();
      step();
      check("reset_active_rate", 32'(active_rate), 32'd80);
      check("reset_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      step();

      // Idle channel: strobe must not reach the integrators.
      pulse(1'b0, 2);

      // rate 4, strobe every 8 clocks
      load_rate(16'd4);
      check("t2_active_rate", 32'(active_rate), 32'd4);
      enable_on();
      for (int i = 1; i <= 8; i++) pulse(i % 4 == 0, 8);
      check("t2_overrun", 32'(overrun), 32'd0);

      // rate 2, strobe every clock: events inside COMB are dropped
      enable_off();
      load_rate(16'd2);
      check("t3_active_rate", 32'(active_rate), 32'd2);
      enable_on();
      pulse(1'b0, 1);
      pulse(1'b1, 1);
      for (int i = 0; i < 5; i++) pulse(1'b0, 1);
      pulse(1'b1, 10);
      check("t3_overrun_set", 32'(overrun), 32'd1);
      load_rate(16'd2);
      check("t3_overrun_clr", 32'(overrun), 32'd0);

      // rate 10, reload to 3 mid-block
      enable_off();
      load_rate(16'd10);
      check("t4_active_10", 32'(active_rate), 32'd10);
      enable_on();
      for (int i = 0; i < 5; i++) pulse(1'b0, 2);
      load_rate(16'd3);
      check("t4_active_kept", 32'(active_rate), 32'd10);
      for (int i = 0; i < 4; i++) pulse(1'b0, 2);
      check("t4_active_before_wrap", 32'(active_rate), 32'd10);
      pulse(1'b1, 8);
      check("t4_active_3", 32'(active_rate), 32'd3);
      for (int i = 1; i <= 6; i++) pulse(i % 3 == 0, 8);
      check("t4_overrun", 32'(overrun), 32'd0);

      // load of 0 in the same cycle as a wrap
      pulse(1'b0, 2);
      pulse(1'b0, 2);
      rate      = '0;
      rate_load = 1'b1;
      pulse(1'b1, 8);
      check("t5_active_1", 32'(active_rate), 32'd1);
      pulse(1'b1, 8);
      pulse(1'b1, 8);

      // enable dropped at comb_sel 1, after an extra sample during COMB
      enable_off();
      load_rate(16'd4);
      check("t6_active_4", 32'(active_rate), 32'd4);
      enable_on();
      for (int i = 0; i < 3; i++) pulse(1'b0, 1);
      pulse(1'b1, 1);
      pulse(1'b0, 1);
      check("t6_sel_at_drop", 32'(comb_sel), 32'd1);
      enable = 1'b0;
      en_q[0] = cyc;
      out_q.delete();
      step();
      model_run = 1'b0;
      repeat (6) step();
      enable_on();
      for (int i = 1; i <= 4; i++) pulse(i == 4, 8);

      // async reset at comb_sel 2
      for (int i = 0; i < 3; i++) pulse(1'b0, 1);
      pulse(1'b1, 3);
      check("t1_sel_before_reset", 32'(comb_sel), 32'd2);
      reset     = 1'b1;
      in_strobe = 1'b1;
      model_run = 1'b0;
      st_q.delete();
      en_q.delete();
      out_q.delete();
      #1;
      check("t1_comb_en", 32'(comb_en), 32'd0);
      check("t1_comb_sel", 32'(comb_sel), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_out_strobe", 32'(out_strobe), 32'd0);
      check("t1_overrun", 32'(overrun), 32'd0);
      check("t1_int_strobe", 32'(int_strobe), 32'd0);
      check("t1_active_rate", 32'(active_rate), 32'd80);
      in_strobe = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      check("t1_active_after_release", 32'(active_rate), 32'd80);
      repeat (8) step();

      // clamp of 0 while idle
      enable_off();
      load_rate(16'd0);
      check("idle_clamp_active", 32'(active_rate), 32'd1);
      repeat (2) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
